// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mul_pkg;

   localparam int unsigned MUL_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } mul_state_e;

endpackage

// File: rtl/mul_addu.sv
// Unsigned WIDTH-bit adder with carry-out, used for the partial-product accumulation.
module mul_addu #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o
);

   assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle shift-add multiplier: magnitude product over WIDTH CALC cycles,
// sign applied in FIX, result held until the next accepted Run.
module shift_add_multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic               Run,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               Ready,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0]   ZERO_W  = '0;
   localparam logic [2*WIDTH-1:0] ZERO_2W = '0;
   localparam logic [CNT_W-1:0]   LAST_IT = CNT_W'(WIDTH - 1);

   // Valid/ready contract: Run is taken only in IDLE; Ready is a single-cycle
   // pulse with product valid from then on; busy covers CALC and FIX.
   mul_state_e           state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 neg_q, neg_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 ready_q, ready_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;

   logic [WIDTH-1:0]     a_abs, b_abs, addend, sum;
   logic                 carry;

   // -(-2^(W-1)) wraps to 2^(W-1), which is exactly the unsigned magnitude.
   assign a_abs = (signed_mode && multiplicand[WIDTH-1]) ? (ZERO_W - multiplicand) : multiplicand;
   assign b_abs = (signed_mode && multiplier[WIDTH-1])   ? (ZERO_W - multiplier)   : multiplier;

   assign addend = lo_q[0] ? mcand_q : ZERO_W;

   mul_addu #(.WIDTH(WIDTH)) u_addu (
      .a_i     (hi_q),
      .b_i     (addend),
      .sum_o   (sum),
      .carry_o (carry)
   );

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      ready_d = 1'b0;
      prod_d  = prod_q;
      case (state_q)
         IDLE: begin
            if (Run) begin
               mcand_d = a_abs;
               hi_d    = ZERO_W;
               lo_d    = b_abs;
               neg_d   = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            hi_d  = {carry, sum[WIDTH-1:1]};
            lo_d  = {sum[0], lo_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IT) begin
               state_d = FIX;
            end
         end
         FIX: begin
            prod_d  = neg_q ? (ZERO_2W - {hi_q, lo_q}) : {hi_q, lo_q};
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         prod_q  <= prod_d;
      end
   end

   assign busy    = busy_q;
   assign Ready   = ready_q;
   assign product = prod_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed checks of the shift-add multiplier at WIDTH=8 and WIDTH=32.
module tb_shift_add_multiplier;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        run8 = 1'b0, sm8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, rdy8;
   logic [15:0] p8;

   logic        run32 = 1'b0, sm32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic        busy32, rdy32;
   logic [63:0] p32;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_add_multiplier #(.WIDTH(8)) dut8 (
      .clk          (clk),
      .Reset        (rst),
      .Run          (run8),
      .signed_mode  (sm8),
      .multiplicand (a8),
      .multiplier   (b8),
      .busy         (busy8),
      .Ready        (rdy8),
      .product      (p8)
   );

   shift_add_multiplier #(.WIDTH(32)) dut32 (
      .clk          (clk),
      .Reset        (rst),
      .Run          (run32),
      .signed_mode  (sm32),
      .multiplicand (a32),
      .multiplier   (b32),
      .busy         (busy32),
      .Ready        (rdy32),
      .product      (p32)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns at #1 after the edge where Ready is seen; edges counted from Run's edge.
   task automatic wait_ready8(output int edges, output int busy_cnt);
      edges = 0;
      busy_cnt = busy8 ? 1 : 0;
      while (edges < 40) begin
         @(posedge clk); #1;
         edges++;
         if (rdy8) break;
         if (busy8) busy_cnt++;
      end
   endtask

   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic [15:0] exp, output int busy_cnt);
      int edges;
      @(negedge clk);
      a8 = a; b8 = b; sm8 = s; run8 = 1'b1;
      @(posedge clk); #1;
      run8 = 1'b0;
      wait_ready8(edges, busy_cnt);
      chk({tag, "_lat"}, 64'(edges), 64'd9);
      chk({tag, "_prod"}, 64'(p8), 64'(exp));
   endtask

   task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] exp);
      int edges;
      @(negedge clk);
      a32 = a; b32 = b; sm32 = s; run32 = 1'b1;
      @(posedge clk); #1;
      run32 = 1'b0;
      edges = 0;
      while (edges < 80) begin
         @(posedge clk); #1;
         edges++;
         if (rdy32) break;
      end
      chk({tag, "_lat"}, 64'(edges), 64'd33);
      chk({tag, "_prod"}, p32, exp);
   endtask

   initial begin
      int bc, edges, pulses, first;
      logic [31:0] ra, rb;
      longint sa, sb;

      // Reset state
      #12;
      chk("rst_busy8", 64'(busy8), 64'd0);
      chk("rst_ready8", 64'(rdy8), 64'd0);
      chk("rst_prod8", 64'(p8), 64'd0);
      chk("rst_prod32", p32, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Basic unsigned op, latency and busy duration, Ready is one cycle
      op8("u13x11", 8'd13, 8'd11, 1'b0, 16'h008F, bc);
      chk("u13x11_busy_cycles", 64'(bc), 64'd9);
      chk("u13x11_busy_at_ready", 64'(busy8), 64'd0);
      @(posedge clk); #1;
      chk("u13x11_ready_pulse", 64'(rdy8), 64'd0);
      chk("u13x11_held", 64'(p8), 64'h008F);

      // Signed/unsigned corners
      op8("s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, bc);
      op8("s_m128sq", 8'h80, 8'h80, 1'b1, 16'h4000, bc);
      op8("u_ffxff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, bc);
      op8("s_m1xm1", 8'hFF, 8'hFF, 1'b1, 16'h0001, bc);
      op8("s_7xm128", 8'h07, 8'h80, 1'b1, 16'hFC80, bc);
      op8("u_zero", 8'h00, 8'h55, 1'b0, 16'h0000, bc);

      // Run pulses while busy are ignored
      @(negedge clk);
      a8 = 8'd9; b8 = 8'd10; sm8 = 1'b0; run8 = 1'b1;
      @(posedge clk); #1;
      run8 = 1'b0; a8 = 8'd3; b8 = 8'd3;
      pulses = 0; first = 0;
      for (int e = 1; e <= 20; e++) begin
         run8 = (e == 3 || e == 5);
         @(posedge clk); #1;
         if (rdy8) begin
            pulses++;
            if (first == 0) first = e;
         end
      end
      run8 = 1'b0;
      chk("ignore_pulses", 64'(pulses), 64'd1);
      chk("ignore_first_ready", 64'(first), 64'd9);
      chk("ignore_prod", 64'(p8), 64'h005A);

      // Back-to-back: Run in the Ready cycle
      op8("b2b_first", 8'd13, 8'd11, 1'b0, 16'h008F, bc);
      a8 = 8'd7; b8 = 8'd6; sm8 = 1'b0; run8 = 1'b1;
      @(posedge clk); #1;
      run8 = 1'b0;
      chk("b2b_ready_drop", 64'(rdy8), 64'd0);
      chk("b2b_busy", 64'(busy8), 64'd1);
      chk("b2b_prod_held", 64'(p8), 64'h008F);
      wait_ready8(edges, bc);
      chk("b2b_lat", 64'(edges), 64'd9);
      chk("b2b_prod", 64'(p8), 64'h002A);

      // Asynchronous reset mid-CALC
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h34; sm8 = 1'b0; run8 = 1'b1;
      @(posedge clk); #1;
      run8 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", 64'(busy8), 64'd0);
      chk("arst_prod", 64'(p8), 64'd0);
      chk("arst_ready", 64'(rdy8), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (rdy8) pulses++;
      end
      chk("arst_no_ready", 64'(pulses), 64'd0);
      chk("arst_prod_after", 64'(p8), 64'd0);
      op8("post_rst", 8'd200, 8'd3, 1'b0, 16'h0258, bc);

      // WIDTH=32
      op32("w32_u", 32'hFFFF_FFFF, 32'h2, 1'b0, 64'h1_FFFF_FFFE);
      op32("w32_s_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = $urandom_range(0, 32'h7FFF_FFFF) ^ (i[0] ? 32'h8000_0000 : 32'h0);
         sa = longint'($signed(ra));
         sb = longint'($signed(rb));
         op32($sformatf("w32_rand%0d", i), ra, rb, 1'b1, 64'(sa * sb));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
